// File: rtl/regdump_pkg.sv
// Shared types and sizing for the register-file debug dump sequencer.
// ST_HDR exists only when REGDUMP_ADDR_HEADER_EN is defined.
package regdump_pkg;

  localparam int DEF_REG_WIDTH = 32;
  localparam int BYTES_PER_REG = DEF_REG_WIDTH / 8;
  localparam int BYTE_IDX_W    = $clog2(BYTES_PER_REG);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
`ifdef REGDUMP_ADDR_HEADER_EN
    ST_HDR,
`endif
    ST_SEND,
    ST_DONE
  } regdump_state_t;

  function automatic int bytes_per_reg(input int width);
    return width / 8;
  endfunction

  // A 1-byte register still needs a 1-bit index counter.
  function automatic int byte_idx_w(input int width);
    return (width / 8 > 1) ? $clog2(width / 8) : 1;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Walks the register file debug port x0..x(NUM_REGS-1), streaming each value
// little-endian over valid/ready. REGDUMP_ADDR_HEADER_EN prefixes each register with its address byte.
module regfile_dump_ctrl
  import regdump_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dump_start_i,
  output logic [4:0]           dbg_addr_o,
  input  logic [REG_WIDTH-1:0] dbg_data_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int BPR = bytes_per_reg(REG_WIDTH);
  localparam int IW  = byte_idx_w(REG_WIDTH);
  localparam logic [IW-1:0] LAST_IDX  = IW'(BPR - 1);
  localparam logic [4:0]    LAST_ADDR = 5'(NUM_REGS - 1);

  if (REG_WIDTH % 8 != 0) begin : g_bad_width
    $error("regfile_dump_ctrl: REG_WIDTH must be a multiple of 8");
  end
  if (NUM_REGS > 32 || NUM_REGS < 1) begin : g_bad_regs
    $error("regfile_dump_ctrl: NUM_REGS must be 1..32");
  end

  regdump_state_t       state_q, state_d;
  logic [4:0]           addr_q, addr_d;
  logic [REG_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (dump_start_i) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        // The whole register is captured here, so it is internally consistent
        // even while the pipeline keeps writing the file.
        shift_d = dbg_data_i;
        idx_d   = '0;
`ifdef REGDUMP_ADDR_HEADER_EN
        state_d = ST_HDR;
`else
        state_d = ST_SEND;
`endif
      end
`ifdef REGDUMP_ADDR_HEADER_EN
      ST_HDR: begin
        if (tx_ready_i) state_d = ST_SEND;
      end
`endif
      ST_SEND: begin
        if (tx_ready_i) begin
          shift_d = shift_q >> 8;
          idx_d   = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            if (addr_q == LAST_ADDR) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + 5'd1;
              state_d = ST_LATCH;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    case (state_q)
      ST_SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = shift_q[7:0];
      end
`ifdef REGDUMP_ADDR_HEADER_EN
      ST_HDR: begin
        tx_valid_o = 1'b1;
        tx_data_o  = {3'b000, addr_q};
      end
`endif
      default: ;
    endcase
  end

  assign dbg_addr_o = addr_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);

endmodule
